// File: rtl/led_blink_arbiter_pkg.sv
// Shared types and constants for the two-button LED blink arbiter.
package led_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        GAP
    } state_t;

    localparam int NUM_CH = 2;

    localparam logic [1:0] BLINKS_CH0 = 2'd1;
    localparam logic [1:0] BLINKS_CH1 = 2'd2;

    function automatic logic [1:0] blink_count(input logic ch);
        return ch ? BLINKS_CH1 : BLINKS_CH0;
    endfunction

endpackage

// File: rtl/led_blink_arbiter_if.sv
// Button inputs and LED/status outputs of the blink arbiter, bundled as one port.
interface led_blink_arbiter_if;

    logic       io_cond0;
    logic       io_cond1;
    logic       io_flag;
    logic       io_busy;
    logic [1:0] io_grant;

    modport master (
        output io_cond0,
        output io_cond1,
        input  io_flag,
        input  io_busy,
        input  io_grant
    );

    modport slave (
        input  io_cond0,
        input  io_cond1,
        output io_flag,
        output io_busy,
        output io_grant
    );

endinterface

// File: rtl/led_blink_arbiter_btn_debounce.sv
// One button channel: 2-FF synchroniser, polarity normalisation, debounce and a
// one-cycle press pulse on the released->pressed transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press_evt
);

    localparam int   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic RELEASED = BTN_ACTIVE_LOW;

    logic          sync1;
    logic          sync2;
    logic          pressed;
    logic          stable;
    logic          stable_q;
    logic [CW-1:0] cnt;

    assign pressed = sync2 ^ BTN_ACTIVE_LOW;

    // The counter only runs while the synced level disagrees with the debounced one
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= RELEASED;
            sync2     <= RELEASED;
            stable    <= 1'b0;
            stable_q  <= 1'b0;
            cnt       <= '0;
            press_evt <= 1'b0;
        end else begin
            sync1     <= raw;
            sync2     <= sync1;
            stable_q  <= stable;
            press_evt <= stable & ~stable_q;
            if (pressed == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= pressed;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_blink_arbiter.sv
// Round-robin sharing of one LED between two buttons; ch0 blinks once, ch1 twice.
// Define LED_ARB_PEND_CNT_EN to queue up to PEND_MAX presses per channel.
module led_blink_arbiter
    import led_arb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLINK_CYCLES    = 6250000,
    parameter int GAP_CYCLES      = 12500000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int PEND_MAX        = 3
) (
    input  logic               clk,
    input  logic               reset,
    led_blink_arbiter_if.slave io
);

    localparam int MAX_PHASE = (BLINK_CYCLES > GAP_CYCLES) ? BLINK_CYCLES : GAP_CYCLES;
    localparam int TW        = $clog2(MAX_PHASE + 1);
    localparam int PEND_W    = $clog2(PEND_MAX + 1);

    // The single-bit mode is the same counter saturating at 1
`ifdef LED_ARB_PEND_CNT_EN
    localparam int PEND_LIMIT = PEND_MAX;
`else
    localparam int PEND_LIMIT = 1;
`endif

    state_t                         state;
    logic [TW-1:0]                  timer;
    logic [1:0]                     blinks;
    logic                           rr;
    logic [NUM_CH-1:0]              press;
    logic [NUM_CH-1:0][PEND_W-1:0]  pend;
    logic [NUM_CH-1:0][PEND_W-1:0]  pend_next;
    logic [NUM_CH-1:0]              pend_nz;
    logic                           sel;
    logic                           take;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_db0 (
        .clk      (clk),
        .reset    (reset),
        .raw      (io.io_cond0),
        .press_evt(press[0])
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_db1 (
        .clk      (clk),
        .reset    (reset),
        .raw      (io.io_cond1),
        .press_evt(press[1])
    );

    // Arbitration and pending bookkeeping; the grant consumes one pending entry
    always_comb begin
        pend_nz   = '0;
        pend_next = pend;
        for (int i = 0; i < NUM_CH; i++) begin
            pend_nz[i] = (pend[i] != '0);
        end
        sel  = (&pend_nz) ? rr : pend_nz[1];
        take = (state == IDLE) && (|pend_nz);
        for (int i = 0; i < NUM_CH; i++) begin
            if (take && (sel == 1'(i))) begin
                pend_next[i] = pend_next[i] - PEND_W'(1);
            end
            if (press[i] && (pend[i] < PEND_W'(PEND_LIMIT))) begin
                pend_next[i] = pend_next[i] + PEND_W'(1);
            end
        end
    end

    // Sequencer: timer is reloaded on every state entry and the phase ends at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            blinks      <= '0;
            rr          <= 1'b0;
            pend        <= '0;
            io.io_flag  <= 1'b0;
            io.io_busy  <= 1'b0;
            io.io_grant <= 2'b00;
        end else begin
            pend <= pend_next;
            case (state)
                IDLE: begin
                    if (take) begin
                        state       <= ON;
                        timer       <= TW'(BLINK_CYCLES - 1);
                        blinks      <= blink_count(sel);
                        rr          <= ~sel;
                        io.io_flag  <= 1'b1;
                        io.io_busy  <= 1'b1;
                        io.io_grant <= sel ? 2'b10 : 2'b01;
                    end
                end
                ON: begin
                    if (timer == '0) begin
                        state      <= OFF;
                        timer      <= TW'(BLINK_CYCLES - 1);
                        blinks     <= blinks - 2'd1;
                        io.io_flag <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                OFF: begin
                    if (timer == '0) begin
                        if (blinks != '0) begin
                            state      <= ON;
                            timer      <= TW'(BLINK_CYCLES - 1);
                            io.io_flag <= 1'b1;
                        end else begin
                            state <= GAP;
                            timer <= TW'(GAP_CYCLES - 1);
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        state       <= IDLE;
                        io.io_busy  <= 1'b0;
                        io.io_grant <= 2'b00;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
